// File: rtl/eq_sweep_pkg.sv
// Shared types and defaults for the exhaustive equivalence sweep controller.
package eq_sweep_pkg;

   localparam int unsigned InWDefault    = 12;
   localparam int unsigned OutWDefault   = 4;
   localparam int unsigned SettleDefault = 1;
   localparam int unsigned TimerW        = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCmp,
      StDone
   } sweep_state_e;

endpackage

// File: rtl/eq_sweep_ctrl_if.sv
// Bundle between the sweep controller (master) and the golden/revised netlist bench (slave).
interface eq_sweep_ctrl_if
   import eq_sweep_pkg::*;
#(
   parameter int unsigned IN_W  = InWDefault,
   parameter int unsigned OUT_W = OutWDefault
);

   logic             start_i;
   logic             abort_i;
   logic [IN_W-1:0]  vec_o;
   logic [OUT_W-1:0] golden_i;
   logic [OUT_W-1:0] revised_i;
   logic             busy_o;
   logic             done_o;
   logic             pass_o;
   logic [IN_W-1:0]  fail_vec_o;
   logic [OUT_W-1:0] fail_diff_o;
   logic [IN_W:0]    mis_cnt_o;

   modport master (
      input  start_i, abort_i, golden_i, revised_i,
      output vec_o, busy_o, done_o, pass_o, fail_vec_o, fail_diff_o, mis_cnt_o
   );

   modport slave (
      output start_i, abort_i, golden_i, revised_i,
      input  vec_o, busy_o, done_o, pass_o, fail_vec_o, fail_diff_o, mis_cnt_o
   );

endinterface

// File: rtl/eq_sweep_timer.sv
// Loadable down-counter used as the per-vector settle timer; expire flags a count of one.
module eq_sweep_timer
   import eq_sweep_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [TimerW-1:0] load_val,
   input  logic              dec,
   output logic [TimerW-1:0] value,
   output logic              expire
);

   logic [TimerW-1:0] value_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (dec && (value_q != '0)) begin
         value_q <= value_q - TimerW'(1);
      end
   end

   assign value  = value_q;
   assign expire = (value_q == TimerW'(1));

endmodule

// File: rtl/eq_sweep_ctrl.sv
// Exhaustive-stimulus sweep controller comparing golden vs revised netlist responses.
// Optional build macro EQ_SWEEP_EARLY_STOP_EN ends the sweep at the first mismatch.
module eq_sweep_ctrl
   import eq_sweep_pkg::*;
#(
   parameter int unsigned IN_W   = InWDefault,
   parameter int unsigned OUT_W  = OutWDefault,
   parameter int unsigned SETTLE = SettleDefault
) (
   input logic             clk,
   input logic             rst_n,
   eq_sweep_ctrl_if.master bus
);

   localparam int unsigned       CntW      = IN_W + 1;
   localparam logic [TimerW-1:0] SettleVal = TimerW'(SETTLE);
   localparam logic [IN_W-1:0]   VecLast   = '1;

   sweep_state_e     state_q;
   logic [IN_W-1:0]  vec_q;
   logic [IN_W-1:0]  fail_vec_q;
   logic [OUT_W-1:0] fail_diff_q;
   logic [CntW-1:0]  mis_cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             first_seen_q;

   logic [OUT_W-1:0]  diff;
   logic              mismatch;
   logic [CntW-1:0]   mis_cnt_nxt;
   logic              last_vec;
   logic              stop_now;
   logic              in_sweep;
   logic              tmr_load;
   logic              tmr_dec;
   logic              tmr_expire;
   logic [TimerW-1:0] tmr_value;

   assign diff        = bus.golden_i ^ bus.revised_i;
   assign mismatch    = (diff != '0);
   assign mis_cnt_nxt = mis_cnt_q + CntW'(mismatch);
   assign last_vec    = (vec_q == VecLast);
   assign in_sweep    = (state_q == StWait) || (state_q == StCmp);

`ifdef EQ_SWEEP_EARLY_STOP_EN
   assign stop_now = last_vec || mismatch;
`else
   assign stop_now = last_vec;
`endif

   assign tmr_load = ((state_q == StIdle) && bus.start_i) || ((state_q == StCmp) && !stop_now);
   assign tmr_dec  = (state_q == StWait);

   eq_sweep_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (SettleVal),
      .dec      (tmr_dec),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         vec_q        <= '0;
         fail_vec_q   <= '0;
         fail_diff_q  <= '0;
         mis_cnt_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         first_seen_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Abort beats any same-cycle compare; captured results are left untouched.
         if (in_sweep && bus.abort_i) begin
            state_q <= StIdle;
            vec_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.start_i) begin
                     vec_q        <= '0;
                     mis_cnt_q    <= '0;
                     fail_vec_q   <= '0;
                     fail_diff_q  <= '0;
                     pass_q       <= 1'b0;
                     first_seen_q <= 1'b0;
                     busy_q       <= 1'b1;
                     state_q      <= (SETTLE == 0) ? StCmp : StWait;
                  end
               end
               StWait: begin
                  if (tmr_expire || (tmr_value == '0)) begin
                     state_q <= StCmp;
                  end
               end
               StCmp: begin
                  mis_cnt_q <= mis_cnt_nxt;
                  if (mismatch && !first_seen_q) begin
                     fail_vec_q   <= vec_q;
                     fail_diff_q  <= diff;
                     first_seen_q <= 1'b1;
                  end
                  if (stop_now) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (mis_cnt_nxt == '0);
                  end else begin
                     vec_q   <= vec_q + IN_W'(1);
                     state_q <= (SETTLE == 0) ? StCmp : StWait;
                  end
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.vec_o       = vec_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.pass_o      = pass_q;
   assign bus.fail_vec_o  = fail_vec_q;
   assign bus.fail_diff_o = fail_diff_q;
   assign bus.mis_cnt_o   = mis_cnt_q;

endmodule
